kuart_console_port: RTL

SoC-side endpoint of the kernel console byte stream. Software writes bytes into a TX FIFO; the block emits them as single-cycle valid pulses on the from-CPU byte stream. Bytes injected on the to-CPU stream (valid/ready) land in an RX FIFO that software pops. The block sits between the CPU peripheral register decode and the simulation/debug byte-stream harness.

---
 rtl/kuart_console_port.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/kuart_console_port.sv
// Kernel console byte-stream endpoint: a software TX FIFO drained as spaced valid pulses,
// and an RX FIFO filled from a valid/ready injection stream.
module kuart_console_port #(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 8,
    parameter int unsigned CHAR_GAP = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tx_wr,
    input  logic [7:0]                  tx_wdata,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    input  logic                        rx_rd,
    output logic [7:0]                  rx_rdata,
    output logic                        rx_empty,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [7:0]                  kuart_from_cpu,
    output logic                        kuart_from_cpu_valid,
    input  logic [7:0]                  kuart_to_cpu,
    input  logic                        kuart_to_cpu_valid,
    output logic                        kuart_to_cpu_ready,
    output logic                        tx_overflow,
    output logic                        rx_overflow,
    input  logic                        sticky_clr,
    output logic                        irq
);

    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam int unsigned GapW = $clog2(CHAR_GAP + 2);

    localparam logic [TxAw:0]   TxFullLvl = (TxAw + 1)'(TX_DEPTH);
    localparam logic [TxAw:0]   TxOne     = (TxAw + 1)'(1);
    localparam logic [RxAw:0]   RxFullLvl = (RxAw + 1)'(RX_DEPTH);
    localparam logic [GapW-1:0] GapLoad   = GapW'(CHAR_GAP);
    localparam logic [GapW-1:0] GapOne    = GapW'(1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEmit = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    logic [7:0]      tx_mem_q [TX_DEPTH];
    logic [TxAw:0]   tx_wptr_q, tx_wptr_d;
    logic [TxAw:0]   tx_rptr_q, tx_rptr_d;
    logic            tx_push, tx_pop;

    logic [7:0]      rx_mem_q [RX_DEPTH];
    logic [RxAw:0]   rx_wptr_q, rx_wptr_d;
    logic [RxAw:0]   rx_rptr_q, rx_rptr_d;
    logic            rx_push, rx_pop, rx_full;

    logic [1:0]      state_q, state_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [7:0]      from_cpu_q, from_cpu_d;
    logic            from_cpu_valid_q, from_cpu_valid_d;
    logic            tx_overflow_q, tx_overflow_d;
    logic            rx_overflow_q, rx_overflow_d;

    // Occupancy from pointers carrying one extra wrap bit.
    assign tx_level = tx_wptr_q - tx_rptr_q;
    assign tx_full  = (tx_level == TxFullLvl);
    assign tx_push  = tx_wr && !tx_full;

    assign rx_level = rx_wptr_q - rx_rptr_q;
    assign rx_full  = (rx_level == RxFullLvl);
    assign rx_empty = (rx_level == '0);
    assign rx_push  = kuart_to_cpu_valid && !rx_full;
    assign rx_pop   = rx_rd && !rx_empty;
    assign rx_rdata = rx_mem_q[rx_rptr_q[RxAw-1:0]];

    assign kuart_to_cpu_ready   = !rx_full;
    assign kuart_from_cpu       = from_cpu_q;
    assign kuart_from_cpu_valid = from_cpu_valid_q;
    assign tx_overflow          = tx_overflow_q;
    assign rx_overflow          = rx_overflow_q;
    assign irq                  = !rx_empty;

    always_comb begin
        state_d          = state_q;
        gap_d            = gap_q;
        tx_pop           = 1'b0;
        from_cpu_d       = from_cpu_q;
        from_cpu_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_level != '0 && gap_q == '0) state_d = StEmit;
            end
            StEmit: begin
                tx_pop           = 1'b1;
                from_cpu_d       = tx_mem_q[tx_rptr_q[TxAw-1:0]];
                from_cpu_valid_d = 1'b1;
                gap_d            = GapLoad;
                if (CHAR_GAP > 0)           state_d = StGap;
                else if (tx_level > TxOne)  state_d = StEmit;
                else                        state_d = StIdle;
            end
            StGap: begin
                gap_d = gap_q - GapOne;
                // Last gap cycle rolls straight into EMIT so exactly CHAR_GAP idle cycles separate pulses.
                if (gap_q <= GapOne) state_d = (tx_level != '0) ? StEmit : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_wptr_d     = tx_wptr_q + {{TxAw{1'b0}}, tx_push};
        tx_rptr_d     = tx_rptr_q + {{TxAw{1'b0}}, tx_pop};
        rx_wptr_d     = rx_wptr_q + {{RxAw{1'b0}}, rx_push};
        rx_rptr_d     = rx_rptr_q + {{RxAw{1'b0}}, rx_pop};
        tx_overflow_d = tx_overflow_q || (tx_wr && tx_full);
        rx_overflow_d = rx_overflow_q || (kuart_to_cpu_valid && rx_full);
        if (sticky_clr) begin
            tx_overflow_d = 1'b0;
            rx_overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_q        <= '0;
            tx_rptr_q        <= '0;
            rx_wptr_q        <= '0;
            rx_rptr_q        <= '0;
            state_q          <= StIdle;
            gap_q            <= '0;
            from_cpu_q       <= 8'h00;
            from_cpu_valid_q <= 1'b0;
            tx_overflow_q    <= 1'b0;
            rx_overflow_q    <= 1'b0;
        end else begin
            tx_wptr_q        <= tx_wptr_d;
            tx_rptr_q        <= tx_rptr_d;
            rx_wptr_q        <= rx_wptr_d;
            rx_rptr_q        <= rx_rptr_d;
            state_q          <= state_d;
            gap_q            <= gap_d;
            from_cpu_q       <= from_cpu_d;
            from_cpu_valid_q <= from_cpu_valid_d;
            tx_overflow_q    <= tx_overflow_d;
            rx_overflow_q    <= rx_overflow_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[TxAw-1:0]] <= tx_wdata;
        if (rx_push) rx_mem_q[rx_wptr_q[RxAw-1:0]] <= kuart_to_cpu;
    end

endmodule
